ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 32 bits.
REQ-002 clk_i  input  1  single clock, all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 start_i  input  1  ID/EX stage holds a RV32M instruction (ALUOp 2'b10, funct7 7'b0000001).
REQ-005 funct3_i  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1_data_i  input  32  operand A (dividend/multiplicand).
REQ-007 rs2_data_i  input  32  operand B (divisor/multiplier).
REQ-008 rd_addr_i  input  5  destination register.
REQ-009 flush_i  input  1  abort in-flight operation.
REQ-010 stall_o  output  1  hold PC, IF/ID and ID/EX registers.
REQ-011 done_o  output  1  result_o valid this cycle, one-cycle pulse.
REQ-012 result_o  output  32  selected 32-bit result.
REQ-013 rd_addr_o  output  5  captured destination register.
REQ-014 RegWrite_o  output  1  equals done_o; write-back enable.

Function
REQ-015 FSM states SHALL be IDLE, BUSY, DONE.
REQ-016 IDLE: start_i=1 and flush_i=0 at an edge -> capture operands, funct3, rd_addr; counter=0; go BUSY, or DONE directly for special cases (REQ-021, REQ-022).
REQ-017 BUSY: one iteration per edge (shift-add multiply or restoring divide on magnitudes); after the 32nd iteration (counter 31) -> DONE.
REQ-018 DONE: done_o=1 for exactly one cycle; next edge -> IDLE, regardless of start_i.
REQ-019 Latency: start accepted at edge N; done_o high in the cycle after edge N+32; special cases give done_o in the cycle after edge N.
REQ-020 stall_o SHALL equal (IDLE and start_i and not flush_i) or BUSY; stall_o=0 in DONE so the pipeline advances the cycle the result is written.
REQ-021 Divide by zero: DIV/DIVU quotient = 32'hFFFFFFFF, REM/REMU remainder = rs1 unchanged.
REQ-022 Signed overflow (DIV/REM, rs1=32'h80000000, rs2=32'hFFFFFFFF): quotient = 32'h80000000, remainder = 0.
REQ-023 Signedness: MULH both signed, MULHSU rs1 signed / rs2 unsigned, MULHU and DIVU/REMU unsigned; signed ops negate magnitudes on entry and fix signs at completion.
REQ-024 Sign rules: product negative iff operand signs differ; quotient negative iff signs differ; remainder takes dividend sign.
REQ-025 MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32] of the full 64-bit product.
REQ-026 flush_i=1 in BUSY or DONE -> IDLE at next edge, done_o and RegWrite_o suppressed; flush_i has priority over start_i in IDLE.
REQ-027 start_i while BUSY or DONE SHALL be ignored; the operation in flight is not restarted.
REQ-028 result_o and rd_addr_o SHALL hold their last values outside DONE; consumers qualify them with done_o.

Reset
REQ-029 rst_i=1 SHALL immediately force IDLE, counter=0, stall_o=0, done_o=0, RegWrite_o=0, result_o=0, rd_addr_o=0, independent of clk_i.
REQ-030 Reset asserted mid-BUSY SHALL discard the operation; after release the block accepts a new start_i on the first edge.

Verification
REQ-031 MUL 7 x -3 (rs1=7, rs2=32'hFFFFFFFD), rd=5 -> stall_o high 33 cycles, done_o pulse, result_o=32'hFFFFFFEB, rd_addr_o=5.
REQ-032 MULHU 32'hFFFFFFFF x 32'hFFFFFFFF -> result_o=32'hFFFFFFFE; MULH same operands -> 0; MULHSU -> 32'hFFFFFFFF.
REQ-033 DIV -7/2 -> 32'hFFFFFFFD; REM -7/2 -> 32'hFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-034 DIVU 5/0 -> 32'hFFFFFFFF and REM 5/0 -> 5, each with done_o one cycle after acceptance; DIV 32'h80000000/-1 -> 32'h80000000.
REQ-035 flush_i at iteration 10 -> IDLE next edge, no done_o; a following MUL 3x4 completes with 12.
REQ-036 rst_i pulsed asynchronously (between edges) at iteration 20 -> outputs zero immediately; back-to-back start_i held through DONE yields a second, independent operation starting at the IDLE edge.

Source files
------------

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv
// Brief    : Iterative RV32M multiply/divide unit for the EX stage. One
//            shift-add or restoring-divide step per clock on operand
//            magnitudes, with signs restored when the result is produced.
//            Divide-by-zero and signed overflow finish in a single cycle.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [4:0]  rd_addr_o,
  output logic        RegWrite_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] hi_q, hi_d;       // product high half / partial remainder
  logic [31:0] lo_q, lo_d;       // multiplier bits / dividend-quotient bits
  logic [31:0] opb_q, opb_d;     // multiplicand magnitude / divisor magnitude
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  rd_out_q, rd_out_d;

  // Entry decode: signedness, magnitudes and single-cycle special cases
  logic        a_signed, b_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        div_by_zero, div_ovf, special;
  logic [31:0] special_res;

  always_comb begin
    a_signed    = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                  (funct3_i == 3'b100) || (funct3_i == 3'b110);
    b_signed    = (funct3_i == 3'b001) || (funct3_i == 3'b100) ||
                  (funct3_i == 3'b110);
    a_neg       = a_signed & rs1_data_i[31];
    b_neg       = b_signed & rs2_data_i[31];
    a_mag       = a_neg ? (32'd0 - rs1_data_i) : rs1_data_i;
    b_mag       = b_neg ? (32'd0 - rs2_data_i) : rs2_data_i;
    div_by_zero = funct3_i[2] && (rs2_data_i == 32'd0);
    div_ovf     = funct3_i[2] && !funct3_i[0] &&
                  (rs1_data_i == 32'h8000_0000) && (rs2_data_i == 32'hFFFF_FFFF);
    special     = div_by_zero || div_ovf;
    if (div_by_zero) begin
      special_res = funct3_i[1] ? rs1_data_i : 32'hFFFF_FFFF;
    end else begin
      special_res = funct3_i[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One datapath iteration: shift-add multiply or restoring divide step
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [31:0] hi_step, lo_step;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : 33'd0);
    div_shift = {hi_q, lo_q[31]};
    div_ge    = div_shift >= {1'b0, opb_q};
    // True difference is below the divisor, so it always fits in 32 bits.
    div_sub   = div_shift[31:0] - opb_q;
    if (op_q[2]) begin
      hi_step = div_ge ? div_sub : div_shift[31:0];
      lo_step = {lo_q[30:0], div_ge};
    end else begin
      hi_step = mul_sum[32:1];
      lo_step = {mul_sum[0], lo_q[31:1]};
    end
  end

  // Sign fix-up and result selection applied to the final iteration's value
  logic [63:0] prod_s;
  logic [31:0] quo_s, rem_s;
  logic [31:0] final_res;

  always_comb begin
    prod_s = neg_res_q ? (64'd0 - {hi_step, lo_step}) : {hi_step, lo_step};
    quo_s  = neg_res_q ? (32'd0 - lo_step) : lo_step;
    rem_s  = neg_rem_q ? (32'd0 - hi_step) : hi_step;
    if (op_q[2]) begin
      final_res = op_q[1] ? rem_s : quo_s;
    end else begin
      final_res = (op_q[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32];
    end
  end

  // Next-state, datapath load/step and handshake outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    rd_out_d  = rd_out_q;
    stall_o   = 1'b0;
    done_o    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          stall_o   = 1'b1;
          op_d      = funct3_i;
          rd_d      = rd_addr_i;
          cnt_d     = 5'd0;
          hi_d      = 32'd0;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          // Divide iterates over the dividend; multiply over the multiplier.
          lo_d      = funct3_i[2] ? a_mag : b_mag;
          opb_d     = funct3_i[2] ? b_mag : a_mag;
          if (special) begin
            state_d  = S_DONE;
            result_d = special_res;
            rd_out_d = rd_addr_i;
          end else begin
            state_d  = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        stall_o = 1'b1;
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          hi_d  = hi_step;
          lo_d  = lo_step;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d  = S_DONE;
            result_d = final_res;
            rd_out_d = rd_q;
          end
        end
      end
      S_DONE: begin
        // The pipeline advances this cycle; a flush cancels the write-back.
        done_o  = !flush_i;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      op_q      <= 3'd0;
      rd_q      <= 5'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      opb_q     <= 32'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= 32'd0;
      rd_out_q  <= 5'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opb_q     <= opb_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
    end
  end

  // Registered result fields are presented directly to write-back
  always_comb begin
    result_o   = result_q;
    rd_addr_o  = rd_out_q;
    RegWrite_o = done_o;
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv
// Brief    : Self-checking bench for ex_muldiv. An arithmetic reference with a
//            latency model is compared against the DUT every cycle; directed
//            vectors carry hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  f3;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd;
  logic        stall_o, done_o, RegWrite_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  int n_cmp = 0;
  int n_bad = 0;

  ex_muldiv dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .funct3_i   (f3),
    .rs1_data_i (rs1),
    .rs2_data_i (rs2),
    .rd_addr_i  (rd),
    .flush_i    (flush),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .rd_addr_o  (rd_addr_o),
    .RegWrite_o (RegWrite_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural result of an RV32M op from plain integer arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    int     si, sj;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    si = a;
    sj = b;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return si / sj;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return si % sj;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    return op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Latency model: 32 cycles busy, or straight to the result for special cases
  bit          m_busy, m_done;
  int          m_remain;
  logic [31:0] m_pend, m_out;
  logic [4:0]  m_pend_rd, m_out_rd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy    <= 1'b0;
      m_done    <= 1'b0;
      m_remain  <= 0;
      m_pend    <= '0;
      m_out     <= '0;
      m_pend_rd <= '0;
      m_out_rd  <= '0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_busy) begin
      if (flush) begin
        m_busy <= 1'b0;
      end else if (m_remain == 1) begin
        m_busy   <= 1'b0;
        m_done   <= 1'b1;
        m_out    <= m_pend;
        m_out_rd <= m_pend_rd;
      end else begin
        m_remain <= m_remain - 1;
      end
    end else if (start && !flush) begin
      if (is_special(f3, rs1, rs2)) begin
        m_done   <= 1'b1;
        m_out    <= ref_result(f3, rs1, rs2);
        m_out_rd <= rd;
      end else begin
        m_busy    <= 1'b1;
        m_remain  <= 32;
        m_pend    <= ref_result(f3, rs1, rs2);
        m_pend_rd <= rd;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("stall", stall_o, m_busy || (!m_busy && !m_done && start && !flush));
      chk("done", done_o, m_done && !flush);
      chk("regwrite", RegWrite_o, m_done && !flush);
      chk("result", result_o, m_out);
      chk("rd_addr", rd_addr_o, m_out_rd);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r);
    start = 1'b1;
    f3    = op;
    rs1   = a;
    rs2   = b;
    rd    = r;
  endtask

  // Called just after the accepting edge; lat counts cycles to the done pulse
  task automatic wait_done(input logic [31:0] exp, input logic [4:0] exp_rd,
                           input int lat, input string nm);
    int cyc    = 0;
    int stalls = 0;
    bit seen   = 0;
    while (!seen && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (stall_o) stalls++;
      if (done_o) seen = 1;
    end
    chk({nm, " done_seen"}, 32'(seen), 32'd1);
    chk({nm, " latency"}, cyc, lat);
    chk({nm, " stall_cycles"}, stalls, lat - 1);
    chk({nm, " result"}, result_o, exp);
    chk({nm, " rd"}, 32'(rd_addr_o), 32'(exp_rd));
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input logic [31:0] exp, input int lat,
                        input string nm);
    @(negedge clk);
    #1;
    issue(op, a, b, r);
    #1;
    chk({nm, " stall_at_start"}, 32'(stall_o), 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(exp, r, lat, nm);
  endtask

  initial begin
    int dones;
    rst = 1'b0; start = 1'b0; flush = 1'b0;
    f3 = 3'd0; rs1 = '0; rs2 = '0; rd = '0;
    #2 rst = 1'b1;
    #1;
    chk("reset stall", 32'(stall_o), 32'd0);
    chk("reset done", 32'(done_o), 32'd0);
    chk("reset result", result_o, 32'd0);
    chk("reset rd", 32'(rd_addr_o), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;

    // Pin the reference model itself
    chk("ref div", ref_result(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("ref rem", ref_result(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("ref mulhsu", ref_result(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    chk("ref mulhu", ref_result(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);

    // Directed arithmetic vectors
    run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33, "mul 7*-3");
    run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 33, "mulhu");
    run_op(3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 33, "mulh -1*-1");
    run_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 33, "mulhsu");
    run_op(3'd1, 32'h8000_0000,  32'h8000_0000, 5'd4,  32'h4000_0000, 33, "mulh min*min");
    run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFD, 33, "div -7/2");
    run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFF, 33, "rem -7/2");
    run_op(3'd5, 32'd100,        32'd7,         5'd8,  32'd14,        33, "divu 100/7");
    run_op(3'd7, 32'd100,        32'd7,         5'd9,  32'd2,         33, "remu 100/7");
    run_op(3'd4, 32'd7,          32'hFFFF_FFFE, 5'd10, 32'hFFFF_FFFD, 33, "div 7/-2");
    run_op(3'd6, 32'd7,          32'hFFFF_FFFE, 5'd11, 32'd1,         33, "rem 7/-2");
    run_op(3'd5, 32'hFFFF_FFFF,  32'd10,        5'd16, 32'h1999_9999, 33, "divu max/10");
    run_op(3'd7, 32'hFFFF_FFFF,  32'd10,        5'd17, 32'd5,         33, "remu max/10");
    run_op(3'd5, 32'd5,          32'd0,         5'd12, 32'hFFFF_FFFF, 1,  "divu 5/0");
    run_op(3'd6, 32'd5,          32'd0,         5'd13, 32'd5,         1,  "rem 5/0");
    run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1,  "div ovf");
    run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'd0,         1,  "rem ovf");

    // Flush during BUSY at iteration 10: no write-back, block returns to idle
    @(negedge clk); #1;
    issue(3'd0, 32'd5, 32'd6, 5'd20);
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) dones++;
    end
    chk("flush busy no done", dones, 0);
    chk("flush busy idle stall", 32'(stall_o), 32'd0);
    run_op(3'd0, 32'd3, 32'd4, 5'd21, 32'd12, 33, "mul 3*4 after flush");

    // Flush during the DONE cycle suppresses the write-back pulse
    @(negedge clk); #1;
    issue(3'd5, 32'd9, 32'd0, 5'd18);
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    chk("flush done suppress", 32'(done_o), 32'd0);
    chk("flush done regwrite", 32'(RegWrite_o), 32'd0);
    @(posedge clk); #1 flush = 1'b0;

    // Flush has priority over start in IDLE
    @(negedge clk); #1;
    issue(3'd0, 32'd2, 32'd2, 5'd19);
    flush = 1'b1;
    #1 chk("flush prio stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
    dones = 0;
    repeat (36) begin
      @(negedge clk);
      if (done_o || stall_o) dones++;
    end
    chk("flush prio not accepted", dones, 0);

    // start held through BUSY and DONE: first op is not restarted, second op
    // is accepted on the IDLE edge
    @(negedge clk); #1;
    issue(3'd5, 32'd100, 32'd7, 5'd22);
    @(posedge clk); #1;
    issue(3'd7, 32'd100, 32'd7, 5'd23);
    wait_done(32'd14, 5'd22, 33, "held start first");
    @(posedge clk);
    @(posedge clk); #1 start = 1'b0;
    wait_done(32'd2, 5'd23, 33, "held start second");

    // Asynchronous reset mid-BUSY at iteration 20, then an immediate new op
    @(negedge clk); #1;
    issue(3'd0, 32'd7, 32'd3, 5'd24);
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst stall", 32'(stall_o), 32'd0);
    chk("async rst done", 32'(done_o), 32'd0);
    chk("async rst regwrite", 32'(RegWrite_o), 32'd0);
    chk("async rst result", result_o, 32'd0);
    chk("async rst rd", 32'(rd_addr_o), 32'd0);
    #1 rst = 1'b0;
    issue(3'd0, 32'd3, 32'd5, 5'd25);
    #0.1;
    chk("post rst stall", 32'(stall_o), 32'd1);
    @(posedge clk); #1 start = 1'b0;
    wait_done(32'd15, 5'd25, 33, "mul after reset");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
